axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the memory word-index width; depth is 2^ADDR_W words of 32 bits.
REQ-002 The block SHALL have parameter READ_LAT, default 2, meaning the extra wait cycles between the AR handshake and the first rvalid.
REQ-003 aclk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-004 aresetn  input  1  reset; asynchronous assertion, active-low.
REQ-005 arid/araddr/arlen/arsize/arburst  input  4/32/8/3/2  read address channel; arsize and arburst SHALL be ignored.
REQ-006 arvalid input 1, arready output 1  read address handshake.
REQ-007 rid/rdata/rresp/rlast/rvalid  output  4/32/2/1/1  read data channel; rready input 1.
REQ-008 awid/awaddr/awlen/awsize/awburst  input  4/32/8/3/2  write address channel; awsize and awburst SHALL be ignored.
REQ-009 awvalid input 1, awready output 1  write address handshake.
REQ-010 wdata/wstrb/wlast/wvalid  input  32/4/1/1; wready output 1  write data channel; wid is not a port.
REQ-011 bid/bresp/bvalid  output  4/2/1; bready input 1  write response channel.

Function
REQ-012 The word index SHALL be addr[ADDR_W+1:2]; higher address bits SHALL alias and addr[1:0] SHALL be ignored.
REQ-013 All bursts SHALL be treated as INCR; each beat advances the word index by 1, wrapping modulo 2^ADDR_W.
REQ-014 The read FSM SHALL have states R_IDLE, R_WAIT and R_DATA, and SHALL assert arready only in R_IDLE.
REQ-015 On AR handshake, the block SHALL latch arid, the index and arlen, clear the beat counter, and go to R_WAIT with the wait counter set to READ_LAT (R_DATA directly if READ_LAT=0).
REQ-016 In R_WAIT, the wait counter SHALL decrement each cycle; the FSM SHALL move to R_DATA on the cycle the counter is 0.
REQ-017 With READ_LAT=N, the first rvalid SHALL be high N+1 cycles after the AR handshake edge.
REQ-018 In R_DATA, the block SHALL drive rvalid=1, rdata=mem[index], rid=latched id, rresp=2'b00, and rlast=(beat==latched len); rdata SHALL hold stable while rvalid&~rready.
REQ-019 On an R handshake, the block SHALL return to R_IDLE if rlast, else increment the index and the beat counter.
REQ-020 The write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1); W is accepted only after AW.
REQ-021 On AW handshake, the block SHALL latch awid, the index and awlen, and go to W_DATA.
REQ-022 Each W handshake SHALL write the bytes of mem[index] whose wstrb bit is set; unstrobed bytes SHALL be unchanged.
REQ-023 The burst SHALL end on beat count == awlen; wlast SHALL be ignored; the FSM SHALL then go to W_RESP.
REQ-024 In W_RESP, the block SHALL drive bid=latched awid and bresp=2'b00; on bready it SHALL return to W_IDLE.
REQ-025 Read and write FSMs SHALL run independently and concurrently; a read beat SHALL return data written by any W handshake completed on an earlier edge.
REQ-026 At most one outstanding read and one outstanding write SHALL exist.

Reset
REQ-027 While aresetn=0, both FSMs SHALL be in their IDLE states with all counters 0.
REQ-028 While aresetn=0, the block SHALL drive arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rlast=0, and rid/bid/rresp/bresp/rdata=0.
REQ-029 A reset asserted mid-burst SHALL drop the transaction with no response; memory contents SHALL NOT be reset.

Configuration
REQ-030 Macro AXI_RAM_RAND_DELAY_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) SHALL advance every cycle.
REQ-031 With AXI_RAM_RAND_DELAY_EN defined, arready, awready and wready SHALL be asserted only in their states AND lfsr[0]=1; rvalid and bvalid, once asserted, SHALL hold until their handshake.
REQ-032 With AXI_RAM_RAND_DELAY_EN defined, R_WAIT SHALL exit only when the counter is 0 AND lfsr[1]=1.
REQ-033 Without AXI_RAM_RAND_DELAY_EN, no LFSR SHALL exist and timing SHALL be exactly as REQ-014..REQ-024.

Verification
REQ-034 Single read: preload mem[5]=32'hDEADBEEF; AR araddr=32'h14, arid=1, arlen=0 at cycle 0 with rready=1 -> rvalid high at cycle 3 with rdata=32'hDEADBEEF, rid=1, rlast=1.
REQ-035 Strobed write: AW awaddr=32'h20, awid=1; then W wdata=32'h11223344, wstrb=4'b0101 over mem[8]=0 -> mem[8]=32'h00220044, bvalid with bid=1, bresp=0.
REQ-036 Burst wrap: arlen=3, araddr=(1023<<2), mem[1023]=A, mem[0..2]=B,C,D -> beats A,B,C,D in order, with rlast only on the fourth beat.
REQ-037 Backpressure: rready=0 for 5 cycles during R_DATA -> rvalid stays 1 with rdata/rid stable; the beat completes when rready=1.
REQ-038 Concurrency: write mem[2]=32'h5 completes, then a read of 32'h8 is issued while an unrelated write is in progress -> rdata=32'h5 and both responses are returned.
REQ-039 Reset mid-burst: aresetn=0 during the 2nd beat of a 4-beat read -> rvalid=0 immediately, arready=1 after release, and previously written memory is intact.

Source files
------------

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a 2^ADDR_W x 32 word RAM; reads and writes run as independent FSMs.
// Define AXI_RAM_RAND_DELAY_EN to add LFSR-driven random ready/latency stalls.
module axi_ram_slave #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  // Read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // Read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // Write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // Write data channel
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // Write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned LatW  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [Depth];

  r_state_e          r_state_q, r_state_d;
  logic [3:0]        r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_beat_q, r_beat_d;
  logic [LatW-1:0]   r_wait_q, r_wait_d;
  logic              r_last;

  w_state_e          w_state_q, w_state_d;
  logic [3:0]        w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [7:0]        w_beat_q, w_beat_d;
  logic              mem_we;

  logic ready_ok;
  logic wait_ok;

`ifdef AXI_RAM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ready_ok = lfsr_q[0];
  assign wait_ok  = lfsr_q[1];
`else
  assign ready_ok = 1'b1;
  assign wait_ok  = 1'b1;
`endif

  assign r_last = (r_beat_q == r_len_q);

  // Read FSM
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_wait_d  = r_wait_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rid       = '0;
    rresp     = 2'b00;
    rdata     = '0;
    unique case (r_state_q)
      R_IDLE: begin
        arready = ready_ok;
        if (arvalid && ready_ok) begin
          r_id_d   = arid;
          r_idx_d  = araddr[ADDR_W+1:2];
          r_len_d  = arlen;
          r_beat_d = '0;
          if (READ_LAT == 0) begin
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_WAIT;
            r_wait_d  = LatW'(READ_LAT);
          end
        end
      end
      R_WAIT: begin
        if (r_wait_q == '0) begin
          if (wait_ok) begin
            r_state_d = R_DATA;
          end
        end else begin
          r_wait_d = r_wait_q - 1'b1;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rdata  = mem[r_idx_q];
        rid    = r_id_q;
        rlast  = r_last;
        if (rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d  = r_idx_q + 1'b1;
            r_beat_d = r_beat_q + 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = 2'b00;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready = ready_ok;
        if (awvalid && ready_ok) begin
          w_id_d    = awid;
          w_idx_d   = awaddr[ADDR_W+1:2];
          w_len_d   = awlen;
          w_beat_d  = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = ready_ok;
        if (wvalid && ready_ok) begin
          mem_we = 1'b1;
          // Burst length comes from awlen alone; wlast is not trusted.
          if (w_beat_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_idx_d  = w_idx_q + 1'b1;
            w_beat_d = w_beat_q + 1'b1;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bid    = w_id_q;
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_wait_q  <= '0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_wait_q  <= r_wait_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{arsize, arburst, awsize, awburst, wlast,
                       araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave (default ADDR_W=10, READ_LAT=2).
module tb_axi_ram_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int total = 0;
  int bad   = 0;

  axi_ram_slave dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    awid    = id;
    awaddr  = addr;
    awlen   = len;
    awvalid = 1'b1;
    for (int n = 0; n < 50 && !awready; n++) begin
      @(posedge aclk); #1;
    end
    check_eq("aw_ready", {31'b0, awready}, 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [7:0] len, input logic [31:0] d [4], input logic [3:0] strb);
    for (int b = 0; b <= int'(len); b++) begin
      wdata  = d[b];
      wstrb  = strb;
      wlast  = (b == int'(len));
      wvalid = 1'b1;
      for (int n = 0; n < 50 && !wready; n++) begin
        @(posedge aclk); #1;
      end
      check_eq("w_ready", {31'b0, wready}, 32'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_phase(input logic [3:0] id);
    bready = 1'b1;
    for (int n = 0; n < 50 && !bvalid; n++) begin
      @(posedge aclk); #1;
    end
    check_eq("b_valid", {31'b0, bvalid}, 32'd1);
    check_eq("b_id", {28'b0, bid}, {28'b0, id});
    check_eq("b_resp", {30'b0, bresp}, 32'd0);
    @(posedge aclk); #1;
    bready = 1'b0;
    check_eq("b_done", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [31:0] d [4], output int lat);
    int n;
    lat     = 0;
    rready  = 1'b1;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arvalid = 1'b1;
    for (int k = 0; k < 50 && !arready; k++) begin
      @(posedge aclk); #1;
    end
    check_eq("ar_ready", {31'b0, arready}, 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 50) begin
        @(posedge aclk); #1;
        n++;
      end
      if (b == 0) lat = n;
      check_eq($sformatf("r_valid%0d", b), {31'b0, rvalid}, 32'd1);
      check_eq($sformatf("r_data%0d", b), rdata, d[b]);
      check_eq($sformatf("r_id%0d", b), {28'b0, rid}, {28'b0, id});
      check_eq($sformatf("r_last%0d", b), {31'b0, rlast}, (b == int'(len)) ? 32'd1 : 32'd0);
      check_eq($sformatf("r_resp%0d", b), {30'b0, rresp}, 32'd0);
      @(posedge aclk); #1;
    end
    check_eq("r_done", {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] dv [4];
    int lat;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // Reset values
    #12;
    check_eq("rst_ctl", {26'b0, arready, awready, wready, rvalid, bvalid, rlast},
             {26'b0, 6'b110000});
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_ids", {20'b0, rid, bid, rresp, bresp}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single read with latency
    dv = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    aw_phase(4'd2, 32'h14, 8'd0); w_phase(8'd0, dv, 4'hF); b_phase(4'd2);
    rd(4'd1, 32'h14, 8'd0, dv, lat);
    check_eq("rd_latency", 32'(lat), 32'd3);

    // Address aliasing: upper bits and byte offset ignored
    rd(4'd6, 32'h0000_1017, 8'd0, dv, lat);

    // Strobed write over zero
    dv = '{32'h0, 32'h0, 32'h0, 32'h0};
    aw_phase(4'd0, 32'h20, 8'd0); w_phase(8'd0, dv, 4'hF); b_phase(4'd0);
    dv = '{32'h11223344, 32'h0, 32'h0, 32'h0};
    aw_phase(4'd1, 32'h20, 8'd0); w_phase(8'd0, dv, 4'b0101); b_phase(4'd1);
    dv = '{32'h00220044, 32'h0, 32'h0, 32'h0};
    rd(4'd5, 32'h20, 8'd0, dv, lat);

    // Burst wrap on write and read
    dv = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003, 32'hD0D00004};
    aw_phase(4'd7, 32'hFFC, 8'd3); w_phase(8'd3, dv, 4'hF); b_phase(4'd7);
    rd(4'd8, 32'hFFC, 8'd3, dv, lat);

    // Backpressure
    rready  = 1'b0;
    arid    = 4'd9;
    araddr  = 32'h20;
    arlen   = 8'd0;
    arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int n = 0; n < 50 && !rvalid; n++) begin
      @(posedge aclk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", {31'b0, rvalid}, 32'd1);
      check_eq("bp_data", rdata, 32'h00220044);
      check_eq("bp_id", {28'b0, rid}, 32'd9);
      check_eq("bp_arready", {31'b0, arready}, 32'd0);
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    check_eq("bp_last", {31'b0, rlast}, 32'd1);
    @(posedge aclk); #1;
    check_eq("bp_done", {31'b0, rvalid}, 32'd0);

    // Concurrency: read while an unrelated write sits in W_DATA
    dv = '{32'h5, 32'h0, 32'h0, 32'h0};
    aw_phase(4'd0, 32'h8, 8'd0); w_phase(8'd0, dv, 4'hF); b_phase(4'd0);
    aw_phase(4'd3, 32'h40, 8'd0);
    check_eq("cc_wready", {31'b0, wready}, 32'd1);
    rd(4'd4, 32'h8, 8'd0, dv, lat);
    dv = '{32'hCAFE0003, 32'h0, 32'h0, 32'h0};
    w_phase(8'd0, dv, 4'hF); b_phase(4'd3);
    rd(4'd4, 32'h40, 8'd0, dv, lat);

    // Reset during the second beat of a 4-beat read
    rready  = 1'b1;
    arid    = 4'd2;
    araddr  = 32'hFFC;
    arlen   = 8'd3;
    arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int n = 0; n < 50 && !rvalid; n++) begin
      @(posedge aclk); #1;
    end
    check_eq("mr_beat0", rdata, 32'hA0A00001);
    @(posedge aclk); #1;
    check_eq("mr_beat1_valid", {31'b0, rvalid}, 32'd1);
    check_eq("mr_beat1", rdata, 32'hB0B00002);
    aresetn = 1'b0;
    #1;
    check_eq("mr_rvalid", {31'b0, rvalid}, 32'd0);
    check_eq("mr_rdata", rdata, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_eq("mr_arready", {31'b0, arready}, 32'd1);
    check_eq("mr_rvalid_after", {31'b0, rvalid}, 32'd0);
    dv = '{32'hA0A00001, 32'hB0B00002, 32'h0, 32'h0};
    rd(4'd2, 32'hFFC, 8'd1, dv, lat);
    dv = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    rd(4'd3, 32'h14, 8'd0, dv, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
